// File: rtl/umi_regbank_pkg.sv
// Shared definitions for the umi_regbank register bank: word offsets and helpers.
package umi_regbank_pkg;

    // Word index (reg_addr[7:2]) of each register.
    localparam logic [5:0] REG_ID      = 6'h00;
    localparam logic [5:0] REG_SCRATCH = 6'h01;
    localparam logic [5:0] REG_CTRL    = 6'h02;
    localparam logic [5:0] REG_STATUS  = 6'h03;
    localparam logic [5:0] REG_EVENT   = 6'h04;
    localparam logic [5:0] REG_IRQEN   = 6'h05;
    localparam logic [5:0] REG_COUNTER = 6'h06;

    // EVENT bit flagging counter overflow: always the MSB of the data word.
    function automatic int unsigned ovf_bit(input int unsigned rw);
        return rw - 1;
    endfunction

endpackage

// File: rtl/umi_regbank_if.sv
// Simple register access bus between umi_regif (master) and the register bank (slave).
interface umi_regbank_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned RW = 32
) ();

    logic [AW-1:0] reg_addr;
    logic          reg_write;
    logic          reg_read;
    logic [RW-1:0] reg_wrdata;
    logic [RW-1:0] reg_rddata;

    modport master (
        output reg_addr,
        output reg_write,
        output reg_read,
        output reg_wrdata,
        input  reg_rddata
    );

    modport slave (
        input  reg_addr,
        input  reg_write,
        input  reg_read,
        input  reg_wrdata,
        output reg_rddata
    );

endinterface

// File: rtl/umi_regbank_evt.sv
// Sticky write-one-to-clear event register; a set pulse beats a clear on the same bit.
module umi_regbank_evt #(
    parameter int unsigned RW = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [RW-1:0] set_i,
    input  logic          wr_i,
    input  logic [RW-1:0] wrdata_i,
    output logic [RW-1:0] q_o
);

    logic [RW-1:0] evt_q;
    logic [RW-1:0] evt_d;

    // Clear the written ones first, then OR in new events so set wins.
    always_comb begin
        evt_d = evt_q;
        if (wr_i) begin
            evt_d = evt_d & ~wrdata_i;
        end
        evt_d = evt_d | set_i;
    end

    // Event state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign q_o = evt_q;

endmodule

// File: rtl/umi_regbank.sv
// Control/status register bank behind umi_regif with one-cycle read latency.
module umi_regbank
    import umi_regbank_pkg::*;
#(
    parameter int unsigned   AW         = 64,
    parameter int unsigned   RW         = 32,
    parameter int unsigned   NEVT       = 8,
    parameter logic [RW-1:0] ID         = 32'h0000_0001,
    parameter logic [RW-1:0] CTRL_RESET = '0
) (
    input  logic              clk,
    input  logic              nreset,
    umi_regbank_if.slave      bus,
    output logic [RW-1:0]     ctrl,
    input  logic [RW-1:0]     status,
    input  logic [NEVT-1:0]   event_in,
    output logic              irq
);

    localparam int unsigned   OVF      = ovf_bit(RW);
    localparam logic [RW-1:0] ONE      = RW'(1);
    // Bits that physically exist in EVENT / IRQ_EN.
    localparam logic [RW-1:0] EVT_MASK = ((ONE << NEVT) - ONE) | (ONE << OVF);

    logic [5:0]    idx;
    logic          unused_addr;
    logic          wr_scratch, wr_ctrl, wr_event, wr_irqen, wr_counter;

    logic [RW-1:0] scratch_q, scratch_d;
    logic [RW-1:0] ctrl_q,    ctrl_d;
    logic [RW-1:0] irqen_q,   irqen_d;
    logic [RW-1:0] cnt_q,     cnt_d;
    logic [RW-1:0] rddata_q,  rddata_d;
    logic          irq_q,     irq_d;
    logic          ovf;
    logic [RW-1:0] evt_set;
    logic [RW-1:0] evt_val;

    // Only reg_addr[7:2] decodes; the rest aliases.
    assign idx         = bus.reg_addr[7:2];
    assign unused_addr = ^{bus.reg_addr[AW-1:8], bus.reg_addr[1:0]};

    assign wr_scratch = bus.reg_write && (idx == REG_SCRATCH);
    assign wr_ctrl    = bus.reg_write && (idx == REG_CTRL);
    assign wr_event   = bus.reg_write && (idx == REG_EVENT);
    assign wr_irqen   = bus.reg_write && (idx == REG_IRQEN);
    assign wr_counter = bus.reg_write && (idx == REG_COUNTER);

    // Next state for the plain RW registers and the counter (write beats increment).
    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        irqen_d   = irqen_q;
        cnt_d     = cnt_q;
        ovf       = 1'b0;
        if (wr_scratch) scratch_d = bus.reg_wrdata;
        if (wr_ctrl)    ctrl_d    = bus.reg_wrdata;
        if (wr_irqen)   irqen_d   = bus.reg_wrdata & EVT_MASK;
        if (wr_counter) begin
            cnt_d = bus.reg_wrdata;
        end else if (ctrl_q[0]) begin
            cnt_d = cnt_q + ONE;
            ovf   = &cnt_q;
        end
    end

    // Event set sources: external pulses in the low bits, overflow in the MSB.
    always_comb begin
        evt_set         = '0;
        evt_set[NEVT-1:0] = event_in;
        evt_set[OVF]    = ovf;
    end

    umi_regbank_evt #(.RW(RW)) u_evt (
        .clk      (clk),
        .nreset   (nreset),
        .set_i    (evt_set),
        .wr_i     (wr_event),
        .wrdata_i (bus.reg_wrdata),
        .q_o      (evt_val)
    );

    // Read mux samples pre-write state; rddata holds between reads.
    always_comb begin
        rddata_d = rddata_q;
        if (bus.reg_read) begin
            case (idx)
                REG_ID:      rddata_d = ID;
                REG_SCRATCH: rddata_d = scratch_q;
                REG_CTRL:    rddata_d = ctrl_q;
                REG_STATUS:  rddata_d = status;
                REG_EVENT:   rddata_d = evt_val;
                REG_IRQEN:   rddata_d = irqen_q;
                REG_COUNTER: rddata_d = cnt_q;
                default:     rddata_d = '0;
            endcase
        end
    end

    // Interrupt from current register state, registered.
    always_comb begin
        irq_d = |(evt_val & irqen_q);
    end

    // Register state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            scratch_q <= '0;
            ctrl_q    <= CTRL_RESET;
            irqen_q   <= '0;
            cnt_q     <= '0;
            rddata_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            irqen_q   <= irqen_d;
            cnt_q     <= cnt_d;
            rddata_q  <= rddata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.reg_rddata = rddata_q;
    assign ctrl           = ctrl_q;
    assign irq            = irq_q;

endmodule
